// File: rtl/pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// pipe_reg_chain
//   Elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage
//   carrying its own valid bit. Valid/ready handshake on both sides, a chain
//   enable that freezes everything, a synchronous flush of the valid bits and
//   a registered occupancy count. Bubbles collapse under downstream stalls,
//   so the chain holds up to DEPTH words and streams at one word per cycle.
//
// Parameters
//   WIDTH      data width in bits
//   DEPTH      number of register stages (1..16)
//   RESET_VAL  value loaded into every stage data register on reset
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (clears valids, loads RESET_VAL)
//   sel        chain enable; 0 freezes all state and masks both handshakes
//   flush      synchronous clear of all valid bits (only while sel=1)
//   in_valid   upstream data valid
//   in_ready   chain can accept in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds valid data
//   out_ready  downstream accepts out_data this cycle
//   out_data   data of the last stage (stage DEPTH-1)
//   count      number of valid stages, 0..DEPTH
// ----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sel,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be in 1..16");
  end

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             active;
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples from the output back to stage 0 within a single process:
  // a stage may load when it is empty or when everything ahead of it moves.
  // This path depends only on valid[] and out_ready, never on in_valid.
  always_comb begin : adv_chain
    logic nxt;
    adv = '0;
    nxt = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = !valid[DEPTH-1-k] || nxt;
      nxt            = adv[DEPTH-1-k];
    end
  end

  // Both handshakes are masked while frozen or flushing.
  assign active    = sel && !flush;
  assign in_ready  = active && adv[0];
  assign out_valid = active && valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data[k] <= RESET_VAL;
      end
    end else if (sel) begin
      if (flush) begin
        // Data registers deliberately keep their contents.
        valid <= '0;
        count <= '0;
      end else begin
        if (adv[0]) begin
          data[0]  <= in_data;
          valid[0] <= in_valid;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
          if (adv[k]) begin
            data[k]  <= data[k-1];
            valid[k] <= valid[k-1];
          end
        end
        // Bubble collapsing never changes the popcount; only the two
        // handshakes do.
        count <= count + CW'(in_xfer) - CW'(out_xfer);
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg_chain
//   Self-checking bench for pipe_reg_chain (WIDTH=32, DEPTH=3, RESET_VAL=0).
//   A table of directed vectors and hand-written multi-cycle sequences carry
//   explicit expected values; a randomized phase is checked against a model
//   that tracks the accepted words as a queue of (data, position) entries.
// ----------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int W = 32;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    count;

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_VAL(32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        sel;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    int          e_cnt;
    logic [31:0] e_od;
    logic        chk_od;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic s, input logic fl, input logic iv,
                              input logic [31:0] id, input logic ordy, input logic eov,
                              input logic eir, input int ecnt, input logic [31:0] eod,
                              input logic cod);
    vec_t v;
    v.rst = rst; v.sel = s; v.flush = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = eov; v.e_ir = eir; v.e_cnt = ecnt; v.e_od = eod; v.chk_od = cod;
    return v;
  endfunction

  // Reference model: words in acceptance order, oldest first, each with the
  // stage it currently occupies. Position D means "left the chain".
  typedef struct {
    logic [31:0] d;
    int          pos;
  } word_t;

  word_t mq[$];
  int    np[16];

  // A word moves one stage forward unless the word ahead of it ends the
  // cycle in the very next stage; the oldest word may leave only if out_ready.
  task automatic model_moves(input logic ordy);
    int lim;
    lim = ordy ? D : D - 1;
    foreach (mq[j]) begin
      np[j] = (mq[j].pos + 1 < lim) ? mq[j].pos + 1 : lim;
      lim   = np[j] - 1;
    end
  endtask

  task automatic step(input vec_t v, input bit tab, input string tag);
    logic  p_ov;
    logic  p_ir;
    logic  free0;
    word_t nq[$];
    word_t w;
    reset = v.rst; sel = v.sel; flush = v.flush;
    in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1;
    model_moves(v.ordy);
    free0 = (mq.size() == 0) || (np[mq.size()-1] > 0);
    p_ov  = v.sel && !v.flush && (mq.size() > 0) && (mq[0].pos == D - 1);
    p_ir  = v.sel && !v.flush && free0;
    chk({tag, ".m_ov"},  32'(out_valid), 32'(p_ov));
    chk({tag, ".m_ir"},  32'(in_ready),  32'(p_ir));
    chk({tag, ".m_cnt"}, 32'(count),     32'(mq.size()));
    if (p_ov) chk({tag, ".m_od"}, out_data, mq[0].d);
    if (tab) begin
      chk({tag, ".ov"},  32'(out_valid), 32'(v.e_ov));
      chk({tag, ".ir"},  32'(in_ready),  32'(v.e_ir));
      chk({tag, ".cnt"}, 32'(count),     32'(v.e_cnt));
      if (v.e_ov || v.chk_od) chk({tag, ".od"}, out_data, v.e_od);
    end
    @(posedge clk);
    if (v.rst) begin
      mq.delete();
    end else if (v.sel) begin
      if (v.flush) begin
        mq.delete();
      end else begin
        foreach (mq[j]) begin
          if (np[j] < D) begin
            w = mq[j];
            w.pos = np[j];
            nq.push_back(w);
          end
        end
        if (v.iv && p_ir) begin
          w.d = v.id;
          w.pos = 0;
          nq.push_back(w);
        end
        mq = nq;
      end
    end
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    reset = 1'b1; sel = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete();

    //          rst sel fl iv  data          ordy eov eir cnt od            cod
    // reset state, then stream with out_ready=1
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   0,  1,  0, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0000abcd, 1,   0,  1,  0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h00001234, 1,   0,  1,  1, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0000cdef, 1,   0,  1,  2, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  3, 32'h0000abcd, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  2, 32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  1, 32'h0000cdef, 0));
    // fill under stall, hold, then drain
    tbl.push_back(mk(0, 1, 0, 1, 32'h00001234, 0,   0,  1,  0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0000cdef, 0,   0,  1,  1, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0000beef, 0,   0,  1,  2, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0000dead, 0,   1,  0,  3, 32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0,   1,  0,  3, 32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  3, 32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  2, 32'h0000cdef, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   1,  1,  1, 32'h0000beef, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1,   0,  1,  0, 32'h0,        0));

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Freeze a full chain; flush is ignored while frozen.
    step(mk(0, 1, 0, 1, 32'h00001234, 0, 0, 1, 0, 32'h0, 0), 1'b1, "frz_fill0");
    step(mk(0, 1, 0, 1, 32'h0000cdef, 0, 0, 1, 1, 32'h0, 0), 1'b1, "frz_fill1");
    step(mk(0, 1, 0, 1, 32'h0000beef, 0, 0, 1, 2, 32'h0, 0), 1'b1, "frz_fill2");
    for (int i = 0; i < 5; i++)
      step(mk(0, 0, (i == 2), 1, 32'h00005555, 1, 0, 0, 3, 32'h0, 0), 1'b1,
           $sformatf("frz%0d", i));
    // Full with out_ready=1: one in, one out on the same edge.
    step(mk(0, 1, 0, 1, 32'h0000aaaa, 1, 1, 1, 3, 32'h00001234, 0), 1'b1, "thaw0");
    step(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 3, 32'h0000cdef, 0), 1'b1, "thaw1");

    // Flush at count=2 together with an offered word.
    step(mk(0, 1, 1, 1, 32'h00002424, 1, 0, 0, 2, 32'h0, 0), 1'b1, "flush0");
    step(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0, 0), 1'b1, "flush1");
    step(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0, 0), 1'b1, "flush2");

    // Reset mid-stream, then a single word traverses.
    step(mk(0, 1, 0, 1, 32'h00001111, 1, 0, 1, 0, 32'h0, 0), 1'b1, "rst0");
    step(mk(0, 1, 0, 1, 32'h00002222, 0, 0, 1, 1, 32'h0, 0), 1'b1, "rst1");
    step(mk(1, 1, 0, 0, 32'h0,        1, 0, 1, 2, 32'h0, 0), 1'b1, "rst2");
    step(mk(0, 1, 0, 1, 32'h0000beef, 0, 0, 1, 0, 32'h0, 1), 1'b1, "rst3");
    step(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 1, 32'h0, 0), 1'b1, "rst4");
    step(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 1, 32'h0, 0), 1'b1, "rst5");
    step(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 32'h0000beef, 0), 1'b1, "rst6");
    step(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0, 0), 1'b1, "rst7");

    // Randomized traffic; the downstream ready probability changes per phase
    // so the chain spends time both empty and full.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 100; c++) begin
        rv = mk(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom(),
                ($urandom_range(0, 5) < ph),
                0, 0, 0, 32'h0, 0);
        step(rv, 1'b0, $sformatf("rnd%0d_%0d", ph, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
